// File: rtl/arf_pkg.sv
// Shared definitions for the address register file.
//   FS_* : encodings of the 2-bit funsel operation select.
package arf_pkg;

   localparam logic [1:0] FS_CLR  = 2'b00;
   localparam logic [1:0] FS_LOAD = 2'b01;
   localparam logic [1:0] FS_DEC  = 2'b10;
   localparam logic [1:0] FS_INC  = 2'b11;

endpackage

// File: rtl/arf_reg_cell.sv
// One register of the address register file.
// Computes its own next value for clear/load/inc/dec, with the inc/dec
// either wrapping or clamping at the ends of the range.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (resets to CLR_VAL)
//   en         : apply funsel on this edge; 0 holds
//   funsel     : 00 clear, 01 load, 10 decrement, 11 increment
//   d          : load data
//   q          : current register value
module arf_reg_cell
   import arf_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter bit               SATURATE = 1'b0,
   parameter logic [WIDTH-1:0] CLR_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       funsel,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_nxt;

   always_comb begin
      q_nxt = q;
      case (funsel)
         FS_CLR:  q_nxt = CLR_VAL;
         FS_LOAD: q_nxt = d;
         FS_DEC: begin
            if (SATURATE && (q == '0)) q_nxt = q;
            else                       q_nxt = q - ONE;
         end
         FS_INC: begin
            if (SATURATE && (q == '1)) q_nxt = q;
            else                       q_nxt = q + ONE;
         end
         default: q_nxt = q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= CLR_VAL;
      else if (en) q <= q_nxt;
   end

endmodule

// File: rtl/arf_param.sv
// Parametrised address register file (AR, SP, PCPrev, PC by default).
// NREG registers sharing one write operation, two combinational read ports,
// automatic capture of the old PC into PCPrev, and stack-pointer bound
// checking with sticky overflow/underflow flags.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   i                    : load data
//   funsel               : 00 clear, 01 load, 10 decrement, 11 increment
//   r_sel                : per-register write select (several may be set)
//   out_a_sel, out_b_sel : read port indices (index >= NREG reads 0)
//   flag_clr             : synchronous clear of sp_ovf / sp_unf
//   out_a, out_b         : read port data
//   sp_ovf               : sticky, decrement attempted with SP at SP_LIMIT
//   sp_unf               : sticky, increment attempted with SP at SP_RESET
module arf_param
   import arf_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter int               NREG       = 4,
   parameter int               SP_IDX     = 1,
   parameter int               PCPREV_IDX = 2,
   parameter int               PC_IDX     = 3,
   parameter logic [WIDTH-1:0] SP_RESET   = 'hFF,
   parameter logic [WIDTH-1:0] SP_LIMIT   = 'h80,
   parameter bit               SATURATE   = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WIDTH-1:0]        i,
   input  logic [1:0]              funsel,
   input  logic [NREG-1:0]         r_sel,
   input  logic [$clog2(NREG)-1:0] out_a_sel,
   input  logic [$clog2(NREG)-1:0] out_b_sel,
   input  logic                    flag_clr,
   output logic [WIDTH-1:0]        out_a,
   output logic [WIDTH-1:0]        out_b,
   output logic                    sp_ovf,
   output logic                    sp_unf
);

   localparam int SELW = $clog2(NREG);
   localparam int NRD  = 2 ** SELW;

   logic [WIDTH-1:0] q      [NREG];
   logic [WIDTH-1:0] d_arr  [NREG];
   logic [1:0]       fs_arr [NREG];
   logic [NREG-1:0]  en;

   logic sp_dec_blk;
   logic sp_inc_blk;
   logic pc_capture;

   // SP bound hits: the SP write is suppressed and the matching flag is set.
   assign sp_dec_blk = r_sel[SP_IDX] && (funsel == FS_DEC) && (q[SP_IDX] == SP_LIMIT);
   assign sp_inc_blk = r_sel[SP_IDX] && (funsel == FS_INC) && (q[SP_IDX] == SP_RESET);

   // Any PC write records the pre-edge PC, unless PCPrev is itself being written.
   assign pc_capture = r_sel[PC_IDX] && !r_sel[PCPREV_IDX];

   always_comb begin
      for (int k = 0; k < NREG; k++) begin
         en[k]     = r_sel[k];
         fs_arr[k] = funsel;
         d_arr[k]  = i;
      end
      if (pc_capture) begin
         en[PCPREV_IDX]     = 1'b1;
         fs_arr[PCPREV_IDX] = FS_LOAD;
         d_arr[PCPREV_IDX]  = q[PC_IDX];
      end
      if (sp_dec_blk || sp_inc_blk) en[SP_IDX] = 1'b0;
   end

   for (genvar k = 0; k < NREG; k++) begin : g_reg
      localparam logic [WIDTH-1:0] CLR_K = (k == SP_IDX) ? SP_RESET : {WIDTH{1'b0}};
      arf_reg_cell #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE),
         .CLR_VAL  (CLR_K)
      ) u_cell (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (en[k]),
         .funsel (fs_arr[k]),
         .d      (d_arr[k]),
         .q      (q[k])
      );
   end

   // Set wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_ovf <= 1'b0;
         sp_unf <= 1'b0;
      end else begin
         if (sp_dec_blk)    sp_ovf <= 1'b1;
         else if (flag_clr) sp_ovf <= 1'b0;
         if (sp_inc_blk)    sp_unf <= 1'b1;
         else if (flag_clr) sp_unf <= 1'b0;
      end
   end

   // Read table padded to a power of two so out-of-range indices read 0.
   logic [WIDTH-1:0] rd [NRD];

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      if (k < NREG) begin : g_used
         assign rd[k] = q[k];
      end else begin : g_pad
         assign rd[k] = '0;
      end
   end

   assign out_a = rd[out_a_sel];
   assign out_b = rd[out_b_sel];

endmodule

// File: tb/tb_arf_param.sv
module tb_arf_param;
   import arf_pkg::*;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b1;
   logic [7:0] i        = '0;
   logic [1:0] funsel   = '0;
   logic [3:0] r_sel    = '0;
   logic [1:0] out_a_sel = '0;
   logic [1:0] out_b_sel = '0;
   logic       flag_clr = 1'b0;

   logic [7:0] out_a [2];
   logic [7:0] out_b [2];
   logic       sp_ovf [2];
   logic       sp_unf [2];

   int vectors     = 0;
   int miscompares = 0;

   // instance 0 wraps, instance 1 saturates; same stimulus to both
   arf_param #(.SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .i(i), .funsel(funsel), .r_sel(r_sel),
      .out_a_sel(out_a_sel), .out_b_sel(out_b_sel), .flag_clr(flag_clr),
      .out_a(out_a[0]), .out_b(out_b[0]), .sp_ovf(sp_ovf[0]), .sp_unf(sp_unf[0])
   );

   arf_param #(.SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .i(i), .funsel(funsel), .r_sel(r_sel),
      .out_a_sel(out_a_sel), .out_b_sel(out_b_sel), .flag_clr(flag_clr),
      .out_a(out_a[1]), .out_b(out_b[1]), .sp_ovf(sp_ovf[1]), .sp_unf(sp_unf[1])
   );

   initial forever #10 clk = ~clk;

   // ---------------- behavioural model ----------------
   // registers: 0 AR, 1 SP, 2 PCPrev, 3 PC ; values kept as plain integers 0..255
   int m [2][4];
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;

   function automatic int next_val(int v, logic [1:0] fs, int d, int clr_v, bit sat);
      case (fs)
         2'b00: return clr_v;
         2'b01: return d;
         2'b10: begin
            if (v == 0) return sat ? 0 : 255;
            return v - 1;
         end
         default: begin
            if (v == 255) return sat ? 255 : 0;
            return v + 1;
         end
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int  old [4];
      bit  set_ovf;
      bit  set_unf;
      if (!rst_n) begin
         for (int s = 0; s < 2; s++)
            for (int k = 0; k < 4; k++) m[s][k] = (k == 1) ? 255 : 0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         set_ovf = 1'b0;
         set_unf = 1'b0;
         for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 4; k++) old[k] = m[s][k];
            for (int k = 0; k < 4; k++) begin
               if (r_sel[k]) begin
                  if (k == 1) begin
                     if (funsel == FS_INC && old[1] == 255)      set_unf = 1'b1;
                     else if (funsel == FS_DEC && old[1] == 128) set_ovf = 1'b1;
                     else m[s][1] = next_val(old[1], funsel, int'(i), 255, s == 1);
                  end else begin
                     m[s][k] = next_val(old[k], funsel, int'(i), 0, s == 1);
                  end
               end
            end
            if (r_sel[3] && !r_sel[2]) m[s][2] = old[3];
         end
         if (set_ovf)       m_ovf = 1'b1;
         else if (flag_clr) m_ovf = 1'b0;
         if (set_unf)       m_unf = 1'b1;
         else if (flag_clr) m_unf = 1'b0;
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         vectors++;
         if (out_a[s] !== 8'(m[s][out_a_sel])) begin
            miscompares++;
            $display("FAIL model_out_a inst%0d sel%0d: got %h expected %h", s, out_a_sel, out_a[s], 8'(m[s][out_a_sel]));
         end
         vectors++;
         if (out_b[s] !== 8'(m[s][out_b_sel])) begin
            miscompares++;
            $display("FAIL model_out_b inst%0d sel%0d: got %h expected %h", s, out_b_sel, out_b[s], 8'(m[s][out_b_sel]));
         end
         vectors++;
         if (sp_ovf[s] !== m_ovf) begin
            miscompares++;
            $display("FAIL model_sp_ovf inst%0d: got %b expected %b", s, sp_ovf[s], m_ovf);
         end
         vectors++;
         if (sp_unf[s] !== m_unf) begin
            miscompares++;
            $display("FAIL model_sp_unf inst%0d: got %b expected %b", s, sp_unf[s], m_unf);
         end
      end
   end

   // ---------------- hand-computed directed checks ----------------
   task automatic chk(input string nm, input int s, input logic [7:0] got, input logic [7:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s inst%0d: got %h expected %h", nm, s, got, want);
      end
   endtask

   // e0/e1 = {AR, SP, PCPrev, PC} expected for the wrap / saturate instances
   task automatic read_all(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                           input bit eo, input bit eu);
      logic [7:0] ex [2][4];
      for (int k = 0; k < 4; k++) begin
         ex[0][k] = e0[8*(3-k) +: 8];
         ex[1][k] = e1[8*(3-k) +: 8];
      end
      for (int k = 0; k < 4; k++) begin
         out_a_sel = 2'(k);
         out_b_sel = 2'(3 - k);
         #1;
         for (int s = 0; s < 2; s++) begin
            chk({nm, "_a"}, s, out_a[s], ex[s][k]);
            chk({nm, "_b"}, s, out_b[s], ex[s][3-k]);
         end
      end
      for (int s = 0; s < 2; s++) begin
         chk({nm, "_ovf"}, s, {7'd0, sp_ovf[s]}, {7'd0, eo});
         chk({nm, "_unf"}, s, {7'd0, sp_unf[s]}, {7'd0, eu});
      end
   endtask

   task automatic op(input logic [1:0] fs, input logic [3:0] sel, input logic [7:0] d, input bit fc);
      funsel   = fs;
      r_sel    = sel;
      i        = d;
      flag_clr = fc;
      @(posedge clk);
      #1;
      r_sel    = '0;
      flag_clr = 1'b0;
   endtask

   initial begin
      // reset without any clock edge
      #1 rst_n = 1'b0;
      #1 read_all("reset", 32'h00FF0000, 32'h00FF0000, 0, 0);
      rst_n = 1'b1;

      // PC loads with PCPrev capture
      op(FS_LOAD, 4'b1000, 8'h3C, 0);
      read_all("pc_load1", 32'h00FF003C, 32'h00FF003C, 0, 0);
      op(FS_LOAD, 4'b1000, 8'h40, 0);
      read_all("pc_load2", 32'h00FF3C40, 32'h00FF3C40, 0, 0);

      // PC increment at all-ones: wrap vs clamp, capture either way
      op(FS_LOAD, 4'b1000, 8'hFF, 0);
      read_all("pc_ff", 32'h00FF40FF, 32'h00FF40FF, 0, 0);
      op(FS_INC, 4'b1000, 8'h00, 0);
      read_all("pc_inc_ff", 32'h00FFFF00, 32'h00FFFFFF, 0, 0);
      op(FS_CLR, 4'b1000, 8'h00, 0);
      read_all("pc_clr", 32'h00FF0000, 32'h00FFFF00, 0, 0);

      // AR decrement at zero: wrap vs clamp
      op(FS_DEC, 4'b0001, 8'h00, 0);
      read_all("ar_dec_0", 32'hFFFF0000, 32'h00FFFF00, 0, 0);
      op(FS_LOAD, 4'b0100, 8'h00, 0);
      op(FS_CLR, 4'b0001, 8'h00, 0);
      read_all("realign", 32'h00FF0000, 32'h00FF0000, 0, 0);

      // SP overflow at the limit
      op(FS_LOAD, 4'b0010, 8'h81, 0);
      op(FS_DEC, 4'b0010, 8'h00, 0);
      read_all("sp_dec1", 32'h00800000, 32'h00800000, 0, 0);
      op(FS_DEC, 4'b0010, 8'h00, 0);
      read_all("sp_dec2", 32'h00800000, 32'h00800000, 1, 0);
      op(FS_DEC, 4'b0010, 8'h00, 0);
      read_all("sp_dec3", 32'h00800000, 32'h00800000, 1, 0);
      op(FS_LOAD, 4'b0000, 8'h00, 1);
      read_all("ovf_clr", 32'h00800000, 32'h00800000, 0, 0);
      op(FS_CLR, 4'b0010, 8'h00, 0);
      read_all("sp_clr", 32'h00FF0000, 32'h00FF0000, 0, 0);

      // SP underflow; set wins over simultaneous clear
      op(FS_INC, 4'b0010, 8'h00, 1);
      read_all("sp_inc_ff", 32'h00FF0000, 32'h00FF0000, 0, 1);
      op(FS_LOAD, 4'b0000, 8'h00, 1);
      read_all("unf_clr", 32'h00FF0000, 32'h00FF0000, 0, 0);

      // multi-select increment; PCPrev selected so its own increment applies
      op(FS_LOAD, 4'b1000, 8'h40, 0);
      op(FS_LOAD, 4'b0001, 8'h10, 0);
      op(FS_LOAD, 4'b0010, 8'h20, 0);
      op(FS_LOAD, 4'b0100, 8'h30, 0);
      read_all("preload", 32'h10203040, 32'h10203040, 0, 0);
      op(FS_INC, 4'b1111, 8'h00, 0);
      read_all("multi_inc", 32'h11213141, 32'h11213141, 0, 0);

      // async reset pulse between edges with an update pending
      funsel = FS_INC;
      r_sel  = 4'b1000;
      #1 rst_n = 1'b0;
      read_all("async_rst", 32'h00FF0000, 32'h00FF0000, 0, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      r_sel = '0;
      read_all("post_rst", 32'h00FF0001, 32'h00FF0001, 0, 0);

      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
